// File: rtl/window_accum.sv
// window_accum: accumulates a stream of DW-bit results over windows of N
// samples and presents the sum, the floor average and the unsigned maximum
// of each window behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_data is the upstream sample
//   ovr_en/ovr_val      when ovr_en is high, ovr_val replaces in_data
//   clear               synchronous flush of the current window or result
//   out_valid/out_ready result handshake
//   out_sum/avg/max     window result (sum, sum >> log2(N), unsigned max)
//   cnt                 samples accepted so far in the current window
module window_accum #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int SW = DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              ovr_en,
    input  logic [DW-1:0]     ovr_val,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_sum,
    output logic [DW-1:0]     out_avg,
    output logic [DW-1:0]     out_max,
    output logic [$clog2(N)-1:0] cnt
);

    localparam int LG = $clog2(N);

    typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   max_q, max_d;
    logic [LG-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [DW-1:0]   avg_q, avg_d;
    logic [DW-1:0]   omax_q, omax_d;

    logic [DW-1:0]   s;
    logic [SW-1:0]   acc_nxt;
    logic [DW-1:0]   max_nxt;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        omax_d  = omax_q;

        s       = ovr_en ? ovr_val : in_data;
        acc_nxt = acc_q + SW'(s);
        // First sample of a window loads max directly.
        max_nxt = (cnt_q == '0 || s > max_q) ? s : max_q;

        case (state_q)
            S_ACCUM: begin
                if (clear) begin
                    // A concurrent beat is consumed but not counted.
                    acc_d = '0;
                    max_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == LG'(N - 1)) begin
                        sum_d   = acc_nxt;
                        avg_d   = acc_nxt[SW-1:LG];
                        omax_d  = max_nxt;
                        acc_d   = '0;
                        max_d   = '0;
                        cnt_d   = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        acc_d = acc_nxt;
                        max_d = max_nxt;
                        cnt_d = cnt_q + LG'(1);
                    end
                end
            end
            S_OUTPUT: begin
                // Result registers keep their value; only the state moves.
                if (clear || out_ready) state_d = S_ACCUM;
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            omax_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            omax_q  <= omax_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUTPUT);
    assign out_sum   = sum_q;
    assign out_avg   = avg_q;
    assign out_max   = omax_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_window_accum.sv
// Bench for window_accum: a table of full windows with expected results,
// plus hand sequences for backpressure, clear and asynchronous reset.
// Expected results go into a scoreboard queue when the last beat of a
// window is driven and are popped when the DUT presents out_valid.
module tb_window_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        ovr_en;
    logic [15:0] ovr_val;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;
    logic [15:0] out_avg;
    logic [15:0] out_max;
    logic [1:0]  cnt;

    window_accum #(.DW(16), .N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ovr_en(ovr_en), .ovr_val(ovr_val), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_avg(out_avg), .out_max(out_max),
        .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] sum;
        logic [15:0] avg;
        logic [15:0] mx;
    } res_t;

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [3:0]       ovr;
        logic [15:0]      ov;
        res_t             r;
    } vec_t;

    res_t sb[$];
    vec_t tbl[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic ovr, input logic [15:0] ov);
        in_valid = 1'b1;
        in_data  = d;
        ovr_en   = ovr;
        ovr_val  = ov;
        step();
        in_valid = 1'b0;
        ovr_en   = 1'b0;
    endtask

    // Wait (bounded) for a result, then compare it against the scoreboard.
    task automatic collect(input string tag);
        int   k;
        res_t r;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            check({tag, "_sum"}, out_sum, r.sum);
            check({tag, "_avg"}, out_avg, r.avg);
            check({tag, "_max"}, out_max, r.mx);
        end
    endtask

    // Drive a full window back to back; the expected result is queued
    // alongside the last beat.
    task automatic run_window(input string tag, input logic [3:0][15:0] d,
                              input logic [3:0] ovr, input logic [15:0] ov,
                              input res_t exp_r, input logic push, input logic rdy);
        out_ready = rdy;
        for (int j = 0; j < 4; j++) begin
            if (j == 3 && push) sb.push_back(exp_r);
            beat(d[j], ovr[j], ov);
            if (j < 3) check({tag, "_cnt"}, cnt, j + 1);
        end
        check({tag, "_latency"}, out_valid, 1'b1);
        if (rdy) begin
            collect(tag);
            step();
            check({tag, "_vld_1cyc"}, out_valid, 1'b0);
            check({tag, "_cnt0"}, cnt, 2'd0);
            check({tag, "_rdy"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests %0d", n_tests);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{d: {16'd10, 16'd8, 16'd6, 16'd4}, ovr: 4'b0000, ov: 16'd0,
                   r: '{sum: 18'd28, avg: 16'd7, mx: 16'd10}};
        tbl[1] = '{d: {16'd4, 16'd3, 16'd2, 16'd1}, ovr: 4'b1111, ov: 16'd9,
                   r: '{sum: 18'd36, avg: 16'd9, mx: 16'd9}};
        tbl[2] = '{d: {16'd4, 16'd3, 16'd2, 16'd1}, ovr: 4'b0000, ov: 16'd9,
                   r: '{sum: 18'd10, avg: 16'd2, mx: 16'd4}};
        tbl[3] = '{d: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, ovr: 4'b0000, ov: 16'd0,
                   r: '{sum: 18'h3FFFC, avg: 16'hFFFF, mx: 16'hFFFF}};
        // override toggles per beat: samples 100, 50, 2, 50
        tbl[4] = '{d: {16'd3, 16'd2, 16'd1, 16'd100}, ovr: 4'b1010, ov: 16'd50,
                   r: '{sum: 18'd202, avg: 16'd50, mx: 16'd100}};
        // unsigned max: 0x8000 beats 0x7FFF
        tbl[5] = '{d: {16'd0, 16'd1, 16'h7FFF, 16'h8000}, ovr: 4'b0000, ov: 16'd0,
                   r: '{sum: 18'h10000, avg: 16'h4000, mx: 16'h8000}};
        tbl[6] = '{d: {16'd3, 16'd3, 16'd3, 16'd3}, ovr: 4'b0000, ov: 16'd0,
                   r: '{sum: 18'd12, avg: 16'd3, mx: 16'd3}};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ovr_en = 1'b0;
        ovr_val = '0; clear = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_vld", out_valid, 1'b0);
        check("rst_sum", out_sum, 18'd0);
        check("rst_cnt", cnt, 2'd0);
        #10 rst_n = 1'b1;
        step();
        check("rst_rdy", in_ready, 1'b1);

        for (int i = 0; i < 6; i++)
            run_window($sformatf("vec%0d", i), tbl[i].d, tbl[i].ovr, tbl[i].ov,
                       tbl[i].r, 1'b1, 1'b1);

        // Backpressure: result held while out_ready is low; an offered beat
        // must not be taken.
        run_window("bp", {16'd1, 16'd1, 16'd1, 16'd1}, 4'b0000, 16'd0,
                   '{sum: 18'd4, avg: 16'd1, mx: 16'd1}, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_vld", out_valid, 1'b1);
            check("bp_sum", out_sum, 18'd4);
            check("bp_rdy", in_ready, 1'b0);
        end
        check("bp_cnt", cnt, 2'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect("bp");
        step();
        check("bp_rel_rdy", in_ready, 1'b1);
        check("bp_rel_vld", out_valid, 1'b0);
        check("bp_hold_sum", out_sum, 18'd4);

        // clear after two beats drops the partial window (including its max)
        beat(16'd5, 1'b0, 16'd0);
        beat(16'd7, 1'b0, 16'd0);
        check("clr_pre_cnt", cnt, 2'd2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_cnt", cnt, 2'd0);
        run_window("clr", {16'd2, 16'd2, 16'd2, 16'd2}, 4'b0000, 16'd0,
                   '{sum: 18'd8, avg: 16'd2, mx: 16'd2}, 1'b1, 1'b1);

        // clear together with a beat: handshake completes, beat is dropped
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd50;
        check("clrbeat_rdy", in_ready, 1'b1);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clrbeat_cnt", cnt, 2'd0);
        run_window("clrbeat", {16'd1, 16'd1, 16'd1, 16'd1}, 4'b0000, 16'd0,
                   '{sum: 18'd4, avg: 16'd1, mx: 16'd1}, 1'b1, 1'b1);

        // clear in OUTPUT discards the result, even with out_ready low
        run_window("clrout", {16'd8, 16'd8, 16'd8, 16'd8}, 4'b0000, 16'd0,
                   '{sum: 18'd32, avg: 16'd8, mx: 16'd8}, 1'b0, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrout_vld", out_valid, 1'b0);
        check("clrout_rdy", in_ready, 1'b1);

        // asynchronous reset mid-window
        beat(16'd9, 1'b0, 16'd0);
        beat(16'd9, 1'b0, 16'd0);
        beat(16'd9, 1'b0, 16'd0);
        check("rstw_pre_cnt", cnt, 2'd3);
        rst_n = 1'b0;
        #1;
        check("rstw_cnt", cnt, 2'd0);
        check("rstw_vld", out_valid, 1'b0);
        #2 rst_n = 1'b1;
        step();

        // asynchronous reset while a result is pending
        run_window("rsto", {16'd9, 16'd9, 16'd9, 16'd9}, 4'b0000, 16'd0,
                   '{sum: 18'd36, avg: 16'd9, mx: 16'd9}, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rsto_vld", out_valid, 1'b0);
        check("rsto_sum", out_sum, 18'd0);
        check("rsto_avg", out_avg, 16'd0);
        check("rsto_max", out_max, 16'd0);
        check("rsto_cnt", cnt, 2'd0);
        #2 rst_n = 1'b1;
        step();
        run_window("post_rst", tbl[6].d, tbl[6].ovr, tbl[6].ov, tbl[6].r, 1'b1, 1'b1);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
